// File: rtl/delay_sum_beamformer_pkg.sv
// Shared defaults and FSM encoding for the delay-and-sum beamformer.
// Derived widths are recomputed from these defaults.
package delay_sum_beamformer_pkg;

    localparam int DEF_NUM_CHANNELS = 4;
    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_BUFFER_DEPTH = 16;
    localparam int DEF_DELAY_WIDTH  = $clog2(DEF_BUFFER_DEPTH);
    localparam int DEF_SUM_WIDTH    = DEF_SAMPLE_WIDTH + $clog2(DEF_NUM_CHANNELS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } bf_state_e;

endpackage

// File: rtl/delay_sum_beamformer_ring.sv
// Per-channel sample history.
// Writes are synchronous at wr_ptr_i; reads are combinational at rd_idx_i.
module sample_ring_buffer
    import delay_sum_beamformer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    localparam int IDX_W       = $clog2(BUFFER_DEPTH)
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        wr_ptr_i,
    input  logic [SAMPLE_WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic [SAMPLE_WIDTH-1:0] rd_data_o
);

    // The contents are not reset; the fill counter in the top masks unwritten slots.
    logic [SAMPLE_WIDTH-1:0] mem_q [BUFFER_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/delay_sum_beamformer.sv
// N-channel delay-and-sum beamformer.
// Each accepted frame is summed one channel per cycle through a single adder.
module delay_sum_beamformer
    import delay_sum_beamformer_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    localparam int DELAY_WIDTH = $clog2(BUFFER_DEPTH),
    localparam int SUM_WIDTH   = SAMPLE_WIDTH + $clog2(NUM_CHANNELS),
    localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 sample_valid,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_in,
    output logic                                 ready,
    input  logic                                 cfg_we,
    input  logic [CH_W-1:0]                      cfg_sel,
    input  logic [DELAY_WIDTH-1:0]               cfg_delay,
    input  logic [NUM_CHANNELS-1:0]              chan_enable,
    input  logic                                 overrun_clr,
    output logic                                 out_valid,
    output logic [SUM_WIDTH-1:0]                 out_sum,
    output logic [SAMPLE_WIDTH-1:0]              out_mean,
    output logic                                 overrun
);

    function automatic logic signed [SUM_WIDTH-1:0] sext(input logic signed [SAMPLE_WIDTH-1:0] s);
        return SUM_WIDTH'(s);
    endfunction

    function automatic logic signed [SAMPLE_WIDTH-1:0] mean_of(input logic signed [SUM_WIDTH-1:0] s);
        logic signed [SUM_WIDTH-1:0] sh;
        sh = s >>> $clog2(NUM_CHANNELS);
        return sh[SAMPLE_WIDTH-1:0];
    endfunction

    bf_state_e state_q, state_d;

    logic [DELAY_WIDTH-1:0]         wr_ptr_q;
    logic [DELAY_WIDTH-1:0]         newest_q;
    logic [DELAY_WIDTH:0]           fill_q;
    logic [DELAY_WIDTH-1:0]         delay_q        [NUM_CHANNELS];
    logic [DELAY_WIDTH-1:0]         shadow_delay_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]        shadow_en_q;
    logic [CH_W-1:0]                ch_q;
    logic signed [SUM_WIDTH-1:0]    acc_q;
    logic signed [SUM_WIDTH-1:0]    out_sum_q;
    logic signed [SAMPLE_WIDTH-1:0] out_mean_q;
    logic                           out_valid_q;
    logic                           overrun_q;

    logic                           accept;
    logic                           last_ch;
    logic [DELAY_WIDTH-1:0]         cur_delay;
    logic [DELAY_WIDTH-1:0]         rd_idx;
    logic signed [SUM_WIDTH-1:0]    term;
    logic signed [SUM_WIDTH-1:0]    acc_next;
    logic [SAMPLE_WIDTH-1:0]        rd_data [NUM_CHANNELS];

    assign ready   = (state_q == IDLE);
    assign accept  = sample_valid & ready;
    assign last_ch = (ch_q == CH_W'(NUM_CHANNELS - 1));

    // Every buffer reads the same index; only the active channel's word is used.
    assign cur_delay = shadow_delay_q[ch_q];
    assign rd_idx    = newest_q - cur_delay;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ring
        sample_ring_buffer #(
            .SAMPLE_WIDTH(SAMPLE_WIDTH),
            .BUFFER_DEPTH(BUFFER_DEPTH)
        ) u_ring (
            .clk      (clk),
            .we_i     (accept),
            .wr_ptr_i (wr_ptr_q),
            .wr_data_i(sample_in[g*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .rd_idx_i (rd_idx),
            .rd_data_o(rd_data[g])
        );
    end

    // A delay reaching past the frames written since reset contributes nothing.
    always_comb begin
        term = '0;
        if (shadow_en_q[ch_q] && ({1'b0, cur_delay} < fill_q)) begin
            term = sext(rd_data[ch_q]);
        end
        acc_next = acc_q + term;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)  state_d = ACCUM;
            ACCUM:   if (last_ch) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_mean_q  <= '0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                delay_q[c] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (cfg_we && (32'(cfg_sel) < NUM_CHANNELS)) begin
                delay_q[cfg_sel] <= cfg_delay;
            end
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (fill_q != (DELAY_WIDTH+1)'(BUFFER_DEPTH)) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
            if ((state_q == ACCUM) && last_ch) begin
                out_sum_q   <= acc_next;
                out_mean_q  <= mean_of(acc_next);
                out_valid_q <= 1'b1;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (sample_valid && !ready) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            newest_q       <= wr_ptr_q;
            shadow_delay_q <= delay_q;
            shadow_en_q    <= chan_enable;
            acc_q          <= '0;
            ch_q           <= '0;
        end else if (state_q == ACCUM) begin
            acc_q <= acc_next;
            ch_q  <= ch_q + 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_mean  = out_mean_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Scoreboard bench for delay_sum_beamformer with default parameters.
module tb_delay_sum_beamformer;

    localparam int N    = 4;
    localparam int SW   = 16;
    localparam int SUMW = 18;
    localparam int BD   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_valid;
    logic [N*SW-1:0]   sample_in;
    logic              ready;
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [3:0]        cfg_delay;
    logic [N-1:0]      chan_enable;
    logic              overrun_clr;
    logic              out_valid;
    logic signed [SUMW-1:0] out_sum;
    logic signed [SW-1:0]   out_mean;
    logic              overrun;

    delay_sum_beamformer dut (
        .clk         (clk),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .ready       (ready),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_delay   (cfg_delay),
        .chan_enable (chan_enable),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .out_sum     (out_sum),
        .out_mean    (out_mean),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [SUMW-1:0] sum;
        logic signed [SW-1:0]   mean;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] hist[$];
    int          mdelay[N];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    // Reference: record frame, then sum each enabled channel's delayed sample.
    task automatic model_accept(input logic [63:0] f, input bit push);
        logic signed [SUMW-1:0] s;
        logic [63:0]            old;
        logic signed [SW-1:0]   smp;
        exp_t                   e;
        hist.push_back(f);
        if (hist.size() > BD) void'(hist.pop_front());
        s = '0;
        for (int c = 0; c < N; c++) begin
            if (chan_enable[c] && mdelay[c] < hist.size()) begin
                old = hist[hist.size() - 1 - mdelay[c]];
                smp = old[c*SW +: SW];
                s   = s + SUMW'(smp);
            end
        end
        e.sum  = s;
        e.mean = SW'(s >>> 2);
        if (push) exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid sum=%0d required=no_result", out_sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_sum !== e.sum || out_mean !== e.mean) begin
                    failures++;
                    $display("FAIL result sum=%0d mean=%0d required sum=%0d mean=%0d",
                             out_sum, out_mean, e.sum, e.mean);
                end
            end
        end
    end

    task automatic do_reset();
        reset        = 1'b1;
        sample_valid = 1'b0;
        cfg_we       = 1'b0;
        overrun_clr  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        hist.delete();
        for (int c = 0; c < N; c++) mdelay[c] = 0;
    endtask

    task automatic cfg(input int sel, input int d);
        cfg_we    = 1'b1;
        cfg_sel   = 2'(sel);
        cfg_delay = 4'(d);
        @(negedge clk);
        cfg_we    = 1'b0;
        mdelay[sel] = d;
    endtask

    task automatic send_frame(input logic [63:0] f, input bit push);
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout ready=%0b required=1", ready);
        end else begin
            sample_valid = 1'b1;
            sample_in    = f;
            model_accept(f, push);
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (ready !== 1'b1)      begin failures++; $display("FAIL rst_ready got=%0b required=1", ready); end
        if (out_valid !== 1'b0)  begin failures++; $display("FAIL rst_out_valid got=%0b required=0", out_valid); end
        if (out_sum !== '0)      begin failures++; $display("FAIL rst_out_sum got=%0d required=0", out_sum); end
        if (out_mean !== '0)     begin failures++; $display("FAIL rst_out_mean got=%0d required=0", out_mean); end
        if (overrun !== 1'b0)    begin failures++; $display("FAIL rst_overrun got=%0b required=0", overrun); end
    endtask

    task automatic test_basic();
        do_reset();
        chan_enable = 4'hF;
        send_frame(pack4(100, 200, 300, 400), 1'b1);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b0 || ready !== 1'b0) begin
                failures++;
                $display("FAIL latency_early cycle=T+%0d out_valid=%0b ready=%0b required 0/0", i, out_valid, ready);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 18'sd1000 || out_mean !== 16'sd250 || ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_T+5 valid=%0b sum=%0d mean=%0d ready=%0b required 1/1000/250/1",
                     out_valid, out_sum, out_mean, ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 18'sd1000) begin
            failures++;
            $display("FAIL hold valid=%0b sum=%0d required 0/1000", out_valid, out_sum);
        end
    endtask

    task automatic test_extremes();
        chan_enable = 4'hF;
        send_frame(pack4(-32768, -32768, -32768, -32768), 1'b1);
        send_frame(pack4(-1, 0, 0, 0), 1'b1);
        send_frame(pack4(32767, 32767, 32767, 32767), 1'b1);
        drain();
    endtask

    task automatic test_delay();
        do_reset();
        chan_enable = 4'b0010;
        cfg(1, 2);
        for (int k = 1; k <= 6; k++) send_frame(pack4(7 * k, 10 * k, -3 * k, 99), 1'b1);
        drain();
    endtask

    task automatic test_wrap();
        do_reset();
        chan_enable = 4'b0001;
        cfg(0, 15);
        for (int k = 1; k <= 20; k++) send_frame(pack4(k, 500, 600, 700), 1'b1);
        drain();
    endtask

    task automatic test_snapshot();
        do_reset();
        chan_enable = 4'hF;
        send_frame(pack4(1, 2, 3, 4), 1'b1);
        chan_enable = 4'b0111;
        cfg(0, 3);
        send_frame(pack4(10, 20, 30, 40), 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        do_reset();
        chan_enable = 4'hF;
        for (int i = 0; i < 22; i++) begin
            sample_valid = 1'b1;
            sample_in    = {$urandom, $urandom};
            if (ready) begin
                model_accept(sample_in, 1'b1);
                accepted++;
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        checks += 2;
        if (accepted != 5) begin failures++; $display("FAIL b2b_accepts got=%0d required=5", accepted); end
        if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun got=%0b required=1", overrun); end
        drain();
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clr got=%0b required=0", overrun); end
        send_frame(pack4(5, 5, 5, 5), 1'b1);
        sample_valid = 1'b1;
        overrun_clr  = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        overrun_clr  = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL set_wins got=%0b required=1", overrun); end
        drain();
    endtask

    task automatic test_reset_midframe();
        do_reset();
        chan_enable = 4'hF;
        send_frame(pack4(1, 2, 3, 4), 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        hist.delete();
        for (int c = 0; c < N; c++) mdelay[c] = 0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b0 || ready !== 1'b1 || out_sum !== '0 || out_mean !== '0) begin
                failures++;
                $display("FAIL midframe_reset valid=%0b ready=%0b sum=%0d mean=%0d required 0/1/0/0",
                         out_valid, ready, out_sum, out_mean);
            end
            @(negedge clk);
        end
        cfg(2, 1);
        send_frame(pack4(5, 6, 7, 8), 1'b1);
        drain();
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        cfg_we       = 1'b0;
        cfg_sel      = '0;
        cfg_delay    = '0;
        chan_enable  = 4'hF;
        overrun_clr  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_delay();
        test_wrap();
        test_snapshot();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit reached required=finish_before_limit");
        $fatal(1, "watchdog");
    end

endmodule
